// File: rtl/pl_pipe_hs.sv
// pl_pipe_hs: elastic, pipelined Ascon linear diffusion layer pL.
// pL is evaluated combinationally on the input.
// The result (or the raw input when bypassed) then moves through LAT
// valid/ready register stages. Bubbles collapse as the stages advance.
// An occupancy counter tracks how many stages hold a transaction.
module pl_pipe_hs #(
  parameter int  LAT   = 2,
  localparam int OCC_W = $clog2(LAT + 1)
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic             flush_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [319:0]     plin_i,
  input  logic             bypass_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [319:0]     plout_o,
  output logic             out_bypass_o,
  output logic [OCC_W-1:0] occupancy_o
);

  generate
    if (LAT < 1 || LAT > 8) begin : g_bad_lat
      $error("pl_pipe_hs: LAT must be in 1..8");
    end
  endgenerate

  // Rotate a 64-bit word right by a constant amount.
  function automatic logic [63:0] ror64(input logic [63:0] x, input int n);
    return (x >> n) | (x << (64 - n));
  endfunction

  // Ascon pL: each word is XORed with two rotations of itself. Words never mix.
  function automatic logic [319:0] ascon_pl(input logic [319:0] s);
    logic [319:0] r;
    r[ 63:  0] = s[ 63:  0] ^ ror64(s[ 63:  0], 19) ^ ror64(s[ 63:  0], 28);
    r[127: 64] = s[127: 64] ^ ror64(s[127: 64], 61) ^ ror64(s[127: 64], 39);
    r[191:128] = s[191:128] ^ ror64(s[191:128],  1) ^ ror64(s[191:128],  6);
    r[255:192] = s[255:192] ^ ror64(s[255:192], 10) ^ ror64(s[255:192], 17);
    r[319:256] = s[319:256] ^ ror64(s[319:256],  7) ^ ror64(s[319:256], 41);
    return r;
  endfunction

  logic [319:0]     data_q [LAT];
  logic [LAT-1:0]   byp_q;
  logic [LAT-1:0]   vld_q;
  logic [LAT-1:0]   vld_d;
  logic [LAT-1:0]   adv;
  logic [OCC_W-1:0] occ_q;
  logic [OCC_W-1:0] occ_d;
  logic [319:0]     stage0_d;
  logic             accept;
  logic             pop;

  // Advance chain, resolved from the output stage back to stage 0.
  // A stage moves on when its successor is empty or is itself moving.
  always_comb begin
    adv          = '0;
    adv[LAT-1]   = vld_q[LAT-1] & out_ready_i;
    for (int k = LAT - 2; k >= 0; k--) begin
      adv[k] = vld_q[k] & (~vld_q[k+1] | adv[k+1]);
    end
  end

  assign in_ready_o = ~flush_i & (~vld_q[0] | adv[0]);
  assign accept     = in_valid_i & in_ready_o;
  assign pop        = vld_q[LAT-1] & out_ready_i;
  assign stage0_d   = bypass_i ? plin_i : ascon_pl(plin_i);

  // Next valid per stage: filled by the upstream move, or holding when not leaving.
  // Flush wipes every valid bit.
  always_comb begin
    vld_d    = '0;
    vld_d[0] = accept | (vld_q[0] & ~adv[0]);
    for (int k = 1; k < LAT; k++) begin
      vld_d[k] = adv[k-1] | (vld_q[k] & ~adv[k]);
    end
    if (flush_i) vld_d = '0;
  end

  // Occupancy bookkeeping: +1 on accept, -1 on output handshake, 0 on flush.
  always_comb begin
    occ_d = occ_q;
    case ({accept, pop})
      2'b10:   occ_d = occ_q + OCC_W'(1);
      2'b01:   occ_d = occ_q - OCC_W'(1);
      default: occ_d = occ_q;
    endcase
    if (flush_i) occ_d = '0;
  end

  // Control state: stage valids and occupancy.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      vld_q <= '0;
      occ_q <= '0;
    end else begin
      vld_q <= vld_d;
      occ_q <= occ_d;
    end
  end

  // Stage data and bypass flag. Loaded only when the stage is being filled.
  // Contents are left untouched on flush.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      for (int k = 0; k < LAT; k++) data_q[k] <= '0;
      byp_q <= '0;
    end else begin
      if (accept) begin
        data_q[0] <= stage0_d;
        byp_q[0]  <= bypass_i;
      end
      for (int k = 1; k < LAT; k++) begin
        if (adv[k-1] && !flush_i) begin
          data_q[k] <= data_q[k-1];
          byp_q[k]  <= byp_q[k-1];
        end
      end
    end
  end

  assign out_valid_o  = vld_q[LAT-1];
  assign plout_o      = data_q[LAT-1];
  assign out_bypass_o = byp_q[LAT-1];
  assign occupancy_o  = occ_q;

endmodule

// File: tb/tb_pl_pipe_hs.sv
// Self-checking bench for pl_pipe_hs (LAT=2).
// Each accepted input pushes its expected result to a queue.
// Each output handshake pops from the queue and compares.
module tb_pl_pipe_hs;

  localparam int LAT   = 2;
  localparam int OCC_W = $clog2(LAT + 1);

  logic             clk = 1'b0;
  logic             reset_i = 1'b1;
  logic             flush_i = 1'b0;
  logic             in_valid_i = 1'b0;
  logic             in_ready_o;
  logic [319:0]     plin_i = '0;
  logic             bypass_i = 1'b0;
  logic             out_valid_o;
  logic             out_ready_i = 1'b1;
  logic [319:0]     plout_o;
  logic             out_bypass_o;
  logic [OCC_W-1:0] occupancy_o;

  int n_tests = 0;
  int n_fail  = 0;

  logic [320:0] sb_q[$];
  logic         stall_prev = 1'b0;
  logic [320:0] prev_out;

  pl_pipe_hs #(.LAT(LAT)) dut (
    .clock_i     (clk),
    .reset_i     (reset_i),
    .flush_i     (flush_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .plin_i      (plin_i),
    .bypass_i    (bypass_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .plout_o     (plout_o),
    .out_bypass_o(out_bypass_o),
    .occupancy_o (occupancy_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [327:0] got, input logic [327:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference pL, rotation written bitwise.
  function automatic logic [63:0] rotr(input logic [63:0] x, input int n);
    logic [63:0] r;
    for (int i = 0; i < 64; i++) r[i] = x[(i + n) % 64];
    return r;
  endfunction

  function automatic logic [319:0] pl_model(input logic [319:0] s);
    int a1[5] = '{19, 61, 1, 10, 7};
    int a2[5] = '{28, 39, 6, 17, 41};
    logic [319:0] r;
    logic [63:0]  w;
    for (int i = 0; i < 5; i++) begin
      w = s[64*i +: 64];
      r[64*i +: 64] = w ^ rotr(w, a1[i]) ^ rotr(w, a2[i]);
    end
    return r;
  endfunction

  function automatic logic [319:0] rnd_state();
    logic [319:0] s;
    for (int i = 0; i < 10; i++) s[32*i +: 32] = $urandom;
    return s;
  endfunction

  // Scoreboard monitor, sampled on the falling edge.
  always @(posedge reset_i) sb_q.delete();

  always @(negedge clk) begin
    if (reset_i) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev)
        chk("stall_hold", {out_valid_o, out_bypass_o, plout_o}, {1'b1, prev_out});
      if (out_valid_o && out_ready_i) begin
        chk("sb_nonempty", sb_q.size() != 0, 1);
        if (sb_q.size() != 0) chk("sb_data", {out_bypass_o, plout_o}, sb_q.pop_front());
      end
      if (flush_i) begin
        sb_q.delete();
      end else if (in_valid_i && in_ready_o) begin
        sb_q.push_back({bypass_i, bypass_i ? plin_i : pl_model(plin_i)});
      end
      stall_prev = out_valid_o && !out_ready_i && !flush_i;
      prev_out   = {out_bypass_o, plout_o};
    end
  end

  task automatic send(input logic [319:0] d, input logic b);
    logic done;
    done = 1'b0;
    plin_i = d; bypass_i = b; in_valid_i = 1'b1;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk); done = in_ready_o;
      @(posedge clk); #1;
    end
    if (!done) chk("send_timeout", 0, 1);
    in_valid_i = 1'b0;
  endtask

  task automatic drain();
    repeat (6) @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [319:0] v3, e, ones, a;
    logic         got_v;
    v3 = {64'h2c342330ea6066d3, 64'hb81a49b9cf6483a8, 64'h5f013068e003b533,
          64'h6569aa62e997dbbb, 64'h3404dc14c532069b};
    ones = '1;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_valid", out_valid_o, 0);
    chk("rst_data", plout_o, 0);
    chk("rst_byp", out_bypass_o, 0);
    chk("rst_occ", occupancy_o, 0);
    chk("rst_ready", in_ready_o, 1);
    @(posedge clk); #1 reset_i = 1'b0;

    // Test 1: x2=1, latency of exactly LAT cycles
    a = '0; a[191:128] = 64'h1;
    plin_i = a; bypass_i = 1'b0; in_valid_i = 1'b1;
    @(negedge clk); chk("t1_c0_valid", out_valid_o, 0);
    @(posedge clk); #1 in_valid_i = 1'b0;
    @(negedge clk); chk("t1_c1_valid", out_valid_o, 0);
    chk("t1_c1_occ", occupancy_o, 1);
    @(negedge clk); chk("t1_c2_valid", out_valid_o, 1);
    e = '0; e[191:128] = 64'h8400000000000001;
    chk("t1_x2", plout_o, e);
    drain();
    chk("empty_occ", occupancy_o, 0);
    chk("empty_ready", in_ready_o, 1);

    // Test 2: x0=1
    a = '0; a[63:0] = 64'h1;
    send(a, 1'b0);
    got_v = 1'b0;
    for (int i = 0; i < 10 && !got_v; i++) begin
      @(negedge clk); got_v = out_valid_o;
    end
    chk("t2_seen", got_v, 1);
    e = '0; e[63:0] = 64'h0000201000000001;
    chk("t2_x0", plout_o, e);
    drain();

    // Test 3: 20 states back to back
    for (int i = 0; i < 20; i++) begin
      plin_i = (i == 0) ? v3 : rnd_state(); bypass_i = 1'b0; in_valid_i = 1'b1;
      @(negedge clk);
      chk("t3_ready", in_ready_o, 1);
      if (i >= LAT) chk("t3_ovld", out_valid_o, 1);
      @(posedge clk); #1;
    end
    in_valid_i = 1'b0;
    drain();

    // Test 4: backpressure for 10 cycles
    out_ready_i = 1'b0;
    send(ones, 1'b0);
    send(rnd_state(), 1'b0);
    plin_i = rnd_state(); in_valid_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("t4_ready", in_ready_o, 0);
      chk("t4_occ", occupancy_o, LAT);
      chk("t4_ones", plout_o, ones);
      @(posedge clk); #1;
    end
    out_ready_i = 1'b1;
    @(negedge clk);
    chk("t4_pass_ready", in_ready_o, 1);
    chk("t4_pass_occ", occupancy_o, LAT);
    @(posedge clk); #1 in_valid_i = 1'b0;
    drain();
    chk("t4_drained", sb_q.size(), 0);

    // Test 5: bypass interleaved with normal transactions
    send(v3, 1'b1);
    send(v3, 1'b0);
    send(rnd_state(), 1'b1);
    send(rnd_state(), 1'b0);
    got_v = 1'b0;
    drain();
    send(v3, 1'b1);
    for (int i = 0; i < 10 && !got_v; i++) begin
      @(negedge clk); got_v = out_valid_o;
    end
    chk("t5_seen", got_v, 1);
    chk("t5_byp_data", {out_bypass_o, plout_o}, {1'b1, v3});
    drain();

    // Test 6a: flush with two in flight, output handshake in the flush cycle
    out_ready_i = 1'b0;
    send(rnd_state(), 1'b0);
    send(rnd_state(), 1'b0);
    @(negedge clk); chk("t6_occ_full", occupancy_o, 2);
    @(posedge clk); #1;
    flush_i = 1'b1; out_ready_i = 1'b1;
    @(negedge clk); chk("t6_flush_ready", in_ready_o, 0);
    @(posedge clk); #1 flush_i = 1'b0;
    chk("t6_flush_valid", out_valid_o, 0);
    chk("t6_flush_occ", occupancy_o, 0);
    send(v3, 1'b0);
    drain();
    chk("t6_flush_drained", sb_q.size(), 0);

    // Test 6b: async reset mid-stream
    out_ready_i = 1'b0;
    send(rnd_state(), 1'b0);
    send(rnd_state(), 1'b0);
    #3 reset_i = 1'b1;
    #1;
    chk("t6_rst_valid", out_valid_o, 0);
    chk("t6_rst_occ", occupancy_o, 0);
    chk("t6_rst_data", plout_o, 0);
    @(posedge clk); @(posedge clk); #1 reset_i = 1'b0;
    out_ready_i = 1'b1;
    send(v3, 1'b0);
    drain();
    chk("t6_rst_drained", sb_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
